// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state codes and helpers for the shift-add multiplier
package seq_mult_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Magnitude of a w-bit operand held zero-extended in 32 bits; the most
    // negative value maps to 2^(w-1), which still fits in w unsigned bits.
    function automatic logic [31:0] abs_w(input logic [31:0] value, input logic signed_flag, input int w);
        return (signed_flag && value[w-1]) ? ~value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/ripple_adder_n.sv
// ripple_adder_n: N-bit ripple-carry adder built from half/full-adder gate equations
module ripple_adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[N];

endmodule

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: iterative shift-add N x N multiplier with valid/ready handshakes
module seq_mult_hs
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int CNT_W = cnt_w(WIDTH);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_mpl;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_co;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_neg_p;
    logic                 w_unused_neg_co;
    logic                 w_accept;

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign out_valid = (r_state == DONE);
    assign out_p     = r_p;
    assign w_accept  = in_valid & in_ready;

    assign w_abs_a   = WIDTH'(abs_w(32'(in_a), in_signed, WIDTH));
    assign w_abs_b   = WIDTH'(abs_w(32'(in_b), in_signed, WIDTH));
    assign w_addend  = r_mpl[0] ? r_mcand : '0;

    // {carry, sum, multiplier} shifted right by one: next accumulator in the top half
    assign w_prod    = {w_co, w_sum, r_mpl[WIDTH-1:1]};

    ripple_adder_n #(.N(WIDTH)) u_add (
        .a    (r_acc),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_co)
    );

    ripple_adder_n #(.N(2*WIDTH)) u_neg (
        .a    (~w_prod),
        .b    ({(2*WIDTH){1'b0}}),
        .cin  (1'b1),
        .sum  (w_neg_p),
        .cout (w_unused_neg_co)
    );

    // Handshake FSM plus one shift-add iteration per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_mpl   <= '0;
            r_neg   <= 1'b0;
            r_p     <= '0;
        end else if (w_accept) begin
            r_state <= BUSY;
            r_cnt   <= '0;
            r_mcand <= w_abs_a;
            r_mpl   <= w_abs_b;
            r_acc   <= '0;
            r_neg   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        end else if (r_state == BUSY) begin
            r_acc <= w_prod[2*WIDTH-1:WIDTH];
            r_mpl <= w_prod[WIDTH-1:0];
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
                r_state <= DONE;
                r_p     <= r_neg ? w_neg_p : w_prod;
            end
        end else if (r_state == DONE && out_ready) begin
            r_state <= IDLE;
        end
    end

endmodule

// File: tb/tb_seq_mult_hs.sv
// tb_seq_mult_hs: scoreboard bench for 8-bit and 16-bit multiplier instances
module tb_seq_mult_hs;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        iv8 = 1'b0, ir8, s8 = 1'b0, ov8, or8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;
    logic        iv16 = 1'b0, ir16, s16 = 1'b0, ov16, or16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] p16;

    seq_mult_hs #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
        .in_signed(s8), .out_valid(ov8), .out_ready(or8), .out_p(p8)
    );

    seq_mult_hs #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
        .in_signed(s16), .out_valid(ov16), .out_ready(or16), .out_p(p16)
    );

    int n_chk = 0, n_pass = 0;
    logic [63:0] q8[$], q16[$];
    int l8[$], l16[$];
    bit seen8 = 0, seen16 = 0;
    int n_xfer8 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s, input int w);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
        if (s && a[w-1]) x = x - (longint'(1) << w);
        if (s && b[w-1]) y = y - (longint'(1) << w);
        return 64'(x * y) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // 8-bit monitor: latency on first sight of out_valid, product on transfer
    always @(negedge clk) begin
        if (ov8 && !seen8) begin
            if (l8.size() == 0) chk("lat8_queue", 64'(l8.size()), 64'(1));
            else chk("lat8", 64'(cyc - l8.pop_front()), 64'(8));
            seen8 = 1;
        end
        if (ov8 && or8) begin
            if (q8.size() == 0) chk("p8_queue", 64'(q8.size()), 64'(1));
            else chk("p8", 64'(p8), q8.pop_front());
            n_xfer8++;
            seen8 = 0;
        end
    end

    // 16-bit monitor
    always @(negedge clk) begin
        if (ov16 && !seen16) begin
            if (l16.size() == 0) chk("lat16_queue", 64'(l16.size()), 64'(1));
            else chk("lat16", 64'(cyc - l16.pop_front()), 64'(16));
            seen16 = 1;
        end
        if (ov16 && or16) begin
            if (q16.size() == 0) chk("p16_queue", 64'(q16.size()), 64'(1));
            else chk("p16", 64'(p16), q16.pop_front());
            seen16 = 0;
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, output int k);
        int t = 0;
        iv8 = 1'b1; a8 = a; b8 = b; s8 = s;
        while (!ir8 && t < 200) begin @(posedge clk); #1; t++; end
        chk("acc8_ready", 64'(ir8), 64'(1));
        k = cyc + 1;
        q8.push_back(ref_mul(32'(a), 32'(b), s, 8));
        l8.push_back(k);
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int t = 0;
        iv16 = 1'b1; a16 = a; b16 = b; s16 = s;
        while (!ir16 && t < 200) begin @(posedge clk); #1; t++; end
        if (!ir16) chk("acc16_ready", 64'(ir16), 64'(1));
        q16.push_back(ref_mul(32'(a), 32'(b), s, 16));
        l16.push_back(cyc + 1);
        @(posedge clk); #1;
        iv16 = 1'b0;
    endtask

    task automatic drain8();
        int t = 0;
        while ((q8.size() != 0 || ov8) && t < 300) begin @(posedge clk); #1; t++; end
        chk("drain8", 64'(q8.size()), 64'(0));
    endtask

    task automatic drain16();
        int t = 0;
        while ((q16.size() != 0 || ov16) && t < 300) begin @(posedge clk); #1; t++; end
        chk("drain16", 64'(q16.size()), 64'(0));
    endtask

    logic [7:0]  ta[7] = '{8'h80, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h03, 8'h80};
    logic [7:0]  tb[7] = '{8'h80, 8'h7F, 8'hFF, 8'h7F, 8'h80, 8'hFB, 8'h80};
    logic        ts[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] c16[5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int k0, k1, k2, t, x;
        logic [15:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov8", 64'(ov8), 64'(0));
        chk("rst_p8", 64'(p8), 64'(0));
        chk("rst_ir8", 64'(ir8), 64'(1));
        chk("rst_ov16", 64'(ov16), 64'(0));
        chk("rst_p16", 64'(p16), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        send8(8'd255, 8'd255, 1'b0, k0);
        chk("ref_fe01", ref_mul(32'd255, 32'd255, 1'b0, 8), 64'hFE01);
        drain8();
        chk("p8_fe01", 64'(p8), 64'hFE01);

        for (int i = 0; i < 7; i++) send8(ta[i], tb[i], ts[i], k0);
        drain8();

        or8 = 1'b0;
        send8(8'd30, 8'd30, 1'b0, k0);
        t = 0;
        while (!ov8 && t < 50) begin @(posedge clk); #1; t++; end
        chk("bp_valid", 64'(ov8), 64'(1));
        iv8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_p", 64'(p8), 64'd900);
            chk("bp_ov", 64'(ov8), 64'(1));
            chk("bp_ir", 64'(ir8), 64'(0));
            @(posedge clk); #1;
        end
        iv8 = 1'b0;
        x = n_xfer8;
        or8 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_one_xfer", 64'(n_xfer8), 64'(x + 1));
        chk("bp_ov_low", 64'(ov8), 64'(0));
        chk("bp_q_empty", 64'(q8.size()), 64'(0));

        send8(8'd8, 8'd8, 1'b0, k0);
        send8(8'd44, 8'd44, 1'b0, k1);
        send8(8'd200, 8'd200, 1'b0, k2);
        chk("b2b_gap1", 64'(k1 - k0), 64'(9));
        chk("b2b_gap2", 64'(k2 - k1), 64'(9));
        drain8();
        chk("b2b_last", 64'(p8), 64'd40000);

        send8(8'd5, 8'd5, 1'b0, k0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_ov", 64'(ov8), 64'(0));
        chk("mid_rst_p", 64'(p8), 64'(0));
        chk("mid_rst_ir", 64'(ir8), 64'(1));
        rst = 1'b0;
        q8.delete();
        l8.delete();
        seen8 = 0;
        x = n_xfer8;
        repeat (12) begin @(posedge clk); #1; end
        chk("mid_rst_no_out", 64'(n_xfer8), 64'(x));
        send8(8'd7, 8'd9, 1'b0, k0);
        drain8();
        chk("after_rst_p", 64'(p8), 64'd63);

        for (int i = 0; i < 1000; i++) begin
            if (i < 50) begin
                ra = c16[i % 5];
                rb = c16[(i / 5) % 5];
                send16(ra, rb, (i >= 25));
            end else begin
                ra = ($urandom_range(0, 3) == 0) ? c16[$urandom_range(0, 4)] : 16'($urandom);
                rb = ($urandom_range(0, 3) == 0) ? c16[$urandom_range(0, 4)] : 16'($urandom);
                send16(ra, rb, 1'($urandom_range(0, 1)));
            end
        end
        drain16();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
